// File: rtl/wg_pkg.sv
// Shared defaults, FSM encoding and row width for the LSTM weight-buffer stream reader.
package wg_pkg;

    localparam int unsigned WG_D_WL      = 24;
    localparam int unsigned WG_UNITS_NUM = 5;
    localparam int unsigned WG_DEPTH     = 156;
    localparam int unsigned WG_ADDR_W    = 8;
    localparam int unsigned ROW_W        = WG_UNITS_NUM * WG_D_WL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wg_state_e;

endpackage

// File: rtl/wg_row_addr_ctr.sv
// Wrapping row-address generator plus remaining-row counter for one burst pass.
module wg_row_addr_ctr
    import wg_pkg::*;
#(
    parameter int unsigned ADDR_W = WG_ADDR_W,
    parameter int unsigned DEPTH  = WG_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_cnt,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0] remaining;

    // Load wins over advance so a pass restart can coincide with the final read.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= load_addr;
            remaining <= load_cnt;
        end else if (advance) begin
            addr      <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last_c = (remaining == CNT_W'(1));

endmodule

// File: rtl/wg_stream_reader.sv
// Weight-buffer read sequencer: streams DEPTH-wrapped rows over valid/ready.
// Optional burst replay is enabled by defining WG_REPEAT_EN.
module wg_stream_reader
    import wg_pkg::*;
#(
    parameter int unsigned D_WL      = WG_D_WL,
    parameter int unsigned UNITS_NUM = WG_UNITS_NUM,
    parameter int unsigned DEPTH     = WG_DEPTH,
    parameter int unsigned ADDR_W    = WG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           first_row,
    input  logic [ADDR_W:0]             num_rows,
`ifdef WG_REPEAT_EN
    input  logic [7:0]                  rep_cnt,
    output logic                        w_pass_last,
`endif
    output logic [ADDR_W-1:0]           buf_addr,
    input  logic [UNITS_NUM*D_WL-1:0]   buf_data,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic [UNITS_NUM*D_WL-1:0]   w_data,
    output logic                        w_last,
    output logic                        busy,
    output logic                        done
);

    wg_state_e         state_q;
    wg_state_e         state_d;
    logic              start_burst;
    logic              zero_done;
    logic              ctr_load;
    logic              ctr_adv;
    logic              ctr_last_c;
    logic              out_load;
    logic              finish;
    logic              w_last_d;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W:0]   ld_cnt;

`ifdef WG_REPEAT_EN
    logic [ADDR_W-1:0] first_q;
    logic [ADDR_W:0]   num_q;
    logic [7:0]        pass_left;
    logic              pass_wrap;
`endif

    wg_row_addr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_addr (ld_addr),
        .load_cnt  (ld_cnt),
        .advance   (ctr_adv),
        .addr      (buf_addr),
        .last_c    (ctr_last_c)
    );

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        start_burst = 1'b0;
        zero_done   = 1'b0;
        ctr_load    = 1'b0;
        ctr_adv     = 1'b0;
        out_load    = 1'b0;
        finish      = 1'b0;
        w_last_d    = ctr_last_c;
        ld_addr     = first_row;
        ld_cnt      = num_rows;
`ifdef WG_REPEAT_EN
        pass_wrap   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        start_burst = 1'b1;
                        ctr_load    = 1'b1;
                        state_d     = RUN;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!w_valid || w_ready) begin
                    out_load = 1'b1;
                    ctr_adv  = 1'b1;
                    if (ctr_last_c) begin
`ifdef WG_REPEAT_EN
                        // Restart the pass in the same cycle so passes abut with no bubble.
                        if (pass_left != '0) begin
                            pass_wrap = 1'b1;
                            ctr_load  = 1'b1;
                            ld_addr   = first_q;
                            ld_cnt    = num_q;
                            w_last_d  = 1'b0;
                        end else begin
                            state_d = DRAIN;
                        end
`else
                        state_d = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                if (w_valid && w_ready) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= zero_done | finish;
            if (start_burst) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (out_load) begin
                w_data  <= buf_data;
                w_valid <= 1'b1;
                w_last  <= w_last_d;
            end else if (finish) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
        end
    end

`ifdef WG_REPEAT_EN
    // Burst parameters retained for pass restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q     <= '0;
            num_q       <= '0;
            pass_left   <= '0;
            w_pass_last <= 1'b0;
        end else begin
            if (start_burst) begin
                first_q   <= first_row;
                num_q     <= num_rows;
                pass_left <= rep_cnt;
            end else if (pass_wrap) begin
                pass_left <= pass_left - 8'd1;
            end
            if (out_load) begin
                w_pass_last <= ctr_last_c;
            end else if (finish) begin
                w_pass_last <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wg_stream_reader.sv
// Directed scoreboard bench for wg_stream_reader (repeat tests need WG_REPEAT_EN).
module tb_wg_stream_reader;
    import wg_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [WG_ADDR_W-1:0] first_row = '0;
    logic [WG_ADDR_W:0]   num_rows = '0;
    logic [WG_ADDR_W-1:0] buf_addr;
    logic [ROW_W-1:0]     buf_data;
    logic                 w_valid;
    logic                 w_ready = 1'b1;
    logic [ROW_W-1:0]     w_data;
    logic                 w_last;
    logic                 busy;
    logic                 done;
`ifdef WG_REPEAT_EN
    logic [7:0]           rep_cnt = '0;
    logic                 w_pass_last;
`endif

    typedef struct {
        logic [ROW_W-1:0] data;
        logic             last;
        logic             plast;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_assert = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    logic             stall_q = 1'b0;
    logic [ROW_W-1:0] hold_data;
    logic             hold_last;

    wg_stream_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_row   (first_row),
        .num_rows    (num_rows),
`ifdef WG_REPEAT_EN
        .rep_cnt     (rep_cnt),
        .w_pass_last (w_pass_last),
`endif
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .w_last      (w_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_W-1:0] row_of(input logic [7:0] a);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int l = 0; l < int'(WG_UNITS_NUM); l++) begin
            r[l*WG_D_WL +: WG_D_WL] = {a, 8'(l), a ^ 8'hA5};
        end
        return r;
    endfunction

    assign buf_data = row_of(buf_addr);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int first, input int num, input int reps);
        exp_t x;
        for (int p = 0; p <= reps; p++) begin
            for (int i = 0; i < num; i++) begin
                x.data  = row_of(8'((first + i) % int'(WG_DEPTH)));
                x.last  = (p == reps) && (i == num - 1);
                x.plast = (i == num - 1);
                q.push_back(x);
            end
        end
    endtask

    task automatic start_burst(input int first, input int num);
        first_row = WG_ADDR_W'(first);
        num_rows  = (WG_ADDR_W+1)'(num);
        start     = 1'b1;
        push_burst(first, num, 0);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 128'(seen), 128'(1));
    endtask

    // Handshake monitor: scoreboard pops and stall-stability checks.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 128'(w_valid), 128'(1));
                chk("hold_data", 128'(w_data), 128'(hold_data));
                chk("hold_last", 128'(w_last), 128'(hold_last));
            end
            if (w_valid && w_ready) begin
                chk("sb_nonempty", 128'(q.size() > 0), 128'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("row_data", 128'(w_data), 128'(e.data));
                    chk("row_last", 128'(w_last), 128'(e.last));
`ifdef WG_REPEAT_EN
                    chk("row_pass_last", 128'(w_pass_last), 128'(e.plast));
`endif
                end
                hs_cnt++;
            end
            stall_q   = w_valid && !w_ready;
            hold_data = w_data;
            hold_last = w_last;
        end
    end

    initial begin
        int base;
        bit [3:0] pat;
        pat = 4'b1001;

        // Reset values
        repeat (3) tick();
        chk("rst_addr", 128'(buf_addr), 128'(0));
        chk("rst_valid", 128'(w_valid), 128'(0));
        chk("rst_data", 128'(w_data), 128'(0));
        chk("rst_last", 128'(w_last), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        tick();

        // Full burst at full rate
        w_ready = 1'b1;
        start_burst(0, 156);
        chk("lat_c1_valid", 128'(w_valid), 128'(0));
        chk("lat_c1_busy", 128'(busy), 128'(1));
        tick();
        chk("lat_c2_valid", 128'(w_valid), 128'(1));
        base = hs_cnt;
        repeat (156) tick();
        chk("full_done", 128'(done), 128'(1));
        chk("full_rows", 128'(hs_cnt - base), 128'(156));
        chk("full_busy", 128'(busy), 128'(0));
        chk("full_sb_empty", 128'(q.size()), 128'(0));
        tick();
        chk("full_done_pulse", 128'(done), 128'(0));

        // Address wrap
        start_burst(154, 4);
        chk("wrap_a0", 128'(buf_addr), 128'(154));
        tick();
        chk("wrap_a1", 128'(buf_addr), 128'(155));
        tick();
        chk("wrap_a2", 128'(buf_addr), 128'(0));
        tick();
        chk("wrap_a3", 128'(buf_addr), 128'(1));
        wait_done(20);
        chk("wrap_sb_empty", 128'(q.size()), 128'(0));
        tick();

        // Backpressure pattern 1,0,0,1
        start_burst(40, 12);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                w_ready = pat[i % 4];
                tick();
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("bp_done_seen", 128'(seen), 128'(1));
        end
        chk("bp_sb_empty", 128'(q.size()), 128'(0));
        w_ready = 1'b1;
        tick();

        // Zero-length burst
        start_burst(7, 0);
        chk("zero_done", 128'(done), 128'(1));
        chk("zero_busy", 128'(busy), 128'(0));
        chk("zero_valid", 128'(w_valid), 128'(0));
        tick();
        chk("zero_done_pulse", 128'(done), 128'(0));
        chk("zero_valid2", 128'(w_valid), 128'(0));

        // Start while busy is ignored
        start_burst(20, 8);
        tick();
        first_row = 8'd100;
        num_rows  = 9'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done(50);
        chk("busy_start_sb_empty", 128'(q.size()), 128'(0));
        repeat (3) tick();
        chk("busy_start_valid", 128'(w_valid), 128'(0));
        chk("busy_start_busy", 128'(busy), 128'(0));

        // Reset after row 10 of 20
        base = hs_cnt;
        start_burst(30, 20);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (hs_cnt - base >= 10) break;
        end
        chk("mid_rows_before_rst", 128'(hs_cnt - base), 128'(10));
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 128'(w_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        q.delete();
        tick();
        chk("mid_post_done", 128'(done), 128'(0));
        start_burst(60, 5);
        chk("mid_new_addr", 128'(buf_addr), 128'(60));
        wait_done(30);
        chk("mid_new_sb_empty", 128'(q.size()), 128'(0));
        tick();

`ifdef WG_REPEAT_EN
        // Replay three passes of rows 5..7
        rep_cnt   = 8'd2;
        first_row = 8'd5;
        num_rows  = 9'd3;
        start     = 1'b1;
        push_burst(5, 3, 2);
        tick();
        start = 1'b0;
        base = hs_cnt;
        wait_done(40);
        chk("rep_rows", 128'(hs_cnt - base), 128'(9));
        chk("rep_sb_empty", 128'(q.size()), 128'(0));
        tick();
        chk("rep_done_pulse", 128'(done), 128'(0));
        rep_cnt = 8'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
